// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants (datapath width, reset PC, NOP encoding, instruction size)
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_BYTES = 4;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus; master = fetch stage (ROM address, IF/ID outputs), slave = ROM/redirect/downstream side
interface if_stage_if;
  import cpu_pkg::*;
  logic [XLEN-1:0] imem_addr;
  logic [31:0] imem_inst;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;
  logic [31:0] out_inst;
  modport master(output imem_addr, out_valid, out_pc, out_pc4, out_inst, input imem_inst, redirect_valid, redirect_pc, out_ready);
  modport slave(input imem_addr, out_valid, out_pc, out_pc4, out_inst, output imem_inst, redirect_valid, redirect_pc, out_ready);
endinterface

// File: rtl/if_stage.sv
// if_stage: PC register + IF/ID output register with valid/ready, redirect flush and stall; ports clk, rst (async high), fetch_en, bus (if_stage_if.master), fetch_cnt
module if_stage
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fetch_en,
  if_stage_if.master b,
  output logic [31:0] fetch_cnt
);
  logic [XLEN-1:0] pc, out_pc, out_pc4;
  logic [31:0] out_inst;
  logic out_valid;
  logic fire, load_ok;
  assign fire = out_valid & b.out_ready;
  assign load_ok = !out_valid | b.out_ready;
  assign b.imem_addr = pc;
  assign b.out_valid = out_valid;
  assign b.out_pc = out_pc;
  assign b.out_pc4 = out_pc4;
  assign b.out_inst = out_inst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      out_valid <= 1'b0;
      out_pc <= '0;
      out_pc4 <= '0;
      out_inst <= NOP_INST;
      fetch_cnt <= '0;
    end else if (b.redirect_valid) begin
      pc <= {b.redirect_pc[XLEN-1:2], 2'b00};
      out_valid <= 1'b0;
      out_inst <= NOP_INST;
    end else if (fetch_en && load_ok) begin
      out_pc <= pc;
      out_pc4 <= pc + INST_BYTES;
      out_inst <= b.imem_inst;
      out_valid <= 1'b1;
      pc <= pc + INST_BYTES;
      fetch_cnt <= fetch_cnt + 32'd1;
    end else if (!fetch_en && fire) begin
      out_valid <= 1'b0;
      out_inst <= NOP_INST;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven check of if_stage fetch, stall, redirect, wrap and async reset
module tb_if_stage;
  logic clk = 0;
  logic rst = 1;
  logic fetch_en = 0;
  logic [31:0] fetch_cnt;
  int cmp = 0;
  int mism = 0;
  if_stage_if bus();
  if_stage dut(.clk(clk), .rst(rst), .fetch_en(fetch_en), .b(bus), .fetch_cnt(fetch_cnt));
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[23:0], 8'h93};
  endfunction
  assign bus.imem_inst = rom(bus.imem_addr);
  typedef struct {
    logic r, fe, rdy, rv;
    logic [31:0] rpc, addr;
    logic ov;
    logic [31:0] opc, opc4, inst, cnt;
  } vec_t;
  vec_t v[19];
  task automatic check(input string n, input int row, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s row %0d: got %h want %h", n, row, act, exp);
    end
  endtask
  task automatic check_all(input int row, input logic [31:0] addr, input logic ov, input logic [31:0] opc, input logic [31:0] opc4, input logic [31:0] inst, input logic [31:0] cnt);
    check("imem_addr", row, bus.imem_addr, addr);
    check("out_valid", row, {31'd0, bus.out_valid}, {31'd0, ov});
    check("out_pc", row, bus.out_pc, opc);
    check("out_pc4", row, bus.out_pc4, opc4);
    check("out_inst", row, bus.out_inst, inst);
    check("fetch_cnt", row, fetch_cnt, cnt);
  endtask
  initial begin
    bus.out_ready = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    v[0]  = '{1,0,0,0,32'h0,        32'h0,        0,32'h0,        32'h0,  32'h13,       0};
    v[1]  = '{1,1,1,0,32'h0,        32'h0,        0,32'h0,        32'h0,  32'h13,       0};
    v[2]  = '{0,1,1,0,32'h0,        32'h4,        1,32'h0,        32'h4,  32'h93,       1};
    v[3]  = '{0,1,1,0,32'h0,        32'h8,        1,32'h4,        32'h8,  32'h493,      2};
    v[4]  = '{0,1,1,0,32'h0,        32'hC,        1,32'h8,        32'hC,  32'h893,      3};
    v[5]  = '{0,1,0,0,32'h0,        32'hC,        1,32'h8,        32'hC,  32'h893,      3};
    v[6]  = '{0,1,0,0,32'h0,        32'hC,        1,32'h8,        32'hC,  32'h893,      3};
    v[7]  = '{0,1,0,0,32'h0,        32'hC,        1,32'h8,        32'hC,  32'h893,      3};
    v[8]  = '{0,1,1,0,32'h0,        32'h10,       1,32'hC,        32'h10, 32'hC93,      4};
    v[9]  = '{0,1,1,1,32'h44,       32'h44,       0,32'hC,        32'h10, 32'h13,       4};
    v[10] = '{0,1,1,0,32'h0,        32'h48,       1,32'h44,       32'h48, 32'h4493,     5};
    v[11] = '{0,1,1,1,32'h47,       32'h44,       0,32'h44,       32'h48, 32'h13,       5};
    v[12] = '{0,1,1,1,32'h100,      32'h100,      0,32'h44,       32'h48, 32'h13,       5};
    v[13] = '{0,1,1,1,32'hFFFFFFFC, 32'hFFFFFFFC, 0,32'h44,       32'h48, 32'h13,       5};
    v[14] = '{0,1,1,0,32'h0,        32'h0,        1,32'hFFFFFFFC, 32'h0,  32'hFFFFFC93, 6};
    v[15] = '{0,1,1,0,32'h0,        32'h4,        1,32'h0,        32'h4,  32'h93,       7};
    v[16] = '{0,0,1,0,32'h0,        32'h4,        0,32'h0,        32'h4,  32'h13,       7};
    v[17] = '{0,0,1,0,32'h0,        32'h4,        0,32'h0,        32'h4,  32'h13,       7};
    v[18] = '{0,0,0,0,32'h0,        32'h4,        0,32'h0,        32'h4,  32'h13,       7};
    #1;
    for (int i = 0; i < 19; i++) begin
      rst = v[i].r;
      fetch_en = v[i].fe;
      bus.out_ready = v[i].rdy;
      bus.redirect_valid = v[i].rv;
      bus.redirect_pc = v[i].rpc;
      @(posedge clk);
      #1;
      check_all(i, v[i].addr, v[i].ov, v[i].opc, v[i].opc4, v[i].inst, v[i].cnt);
    end
    fetch_en = 1;
    bus.out_ready = 0;
    @(posedge clk);
    #1;
    check_all(19, 32'h8, 1, 32'h4, 32'h8, 32'h493, 8);
    #3;
    rst = 1;
    #1;
    check_all(20, 32'h0, 0, 32'h0, 32'h0, 32'h13, 0);
    @(posedge clk);
    #1;
    rst = 0;
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    check_all(21, 32'h4, 1, 32'h0, 32'h4, 32'h93, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
